// File: rtl/key_pkg.sv
// Shared constants and state encoding for the push-button capture front end.
package key_pkg;

    localparam int KEY_W = 8;
    localparam logic [KEY_W-1:0] ONEHOT_RESET = 8'b00000001;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } key_state_t;

    // Exactly one bit set.
    function automatic logic is_onehot(input logic [KEY_W-1:0] v);
        return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
    endfunction

    // Two or more bits set.
    function automatic logic is_multi(input logic [KEY_W-1:0] v);
        return (v & (v - KEY_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; clears to zero on reset.
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop presents a settled value.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_onehot_capture.sv
// Debounced single-key capture for 8 push buttons, feeding a 1-of-8 to BCD decoder.
// Optional auto-repeat of the key_valid strobe while a key stays held is built
// only when KEY_ONEHOT_AUTOREPEAT_EN is defined.
module key_onehot_capture
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] keys_raw,
    output logic [KEY_W-1:0] one_of_8,
    output logic             key_valid,
    output logic             key_held,
    output logic             multi_key
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Count value at which one more matching sample completes the debounce.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [KEY_W-1:0] ks;
    key_state_t       state, state_n;
    logic [KEY_W-1:0] cand, cand_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             accept;
    logic             strobe;

    sync_2ff #(.WIDTH(KEY_W)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (keys_raw),
        .q   (ks)
    );

    // Debounce FSM: next state, candidate key and shared debounce counter.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (is_onehot(ks)) begin
                    cand_n = ks;
                    cnt_n  = CNT_W'(1);
                    if (DEB_LAST == '0) begin
                        state_n = HELD;
                        accept  = 1'b1;
                    end else begin
                        state_n = PRESS_DEB;
                    end
                end
            end
            PRESS_DEB: begin
                if (ks == cand) begin
                    if (cnt >= DEB_LAST) begin
                        state_n = HELD;
                        accept  = 1'b1;
                    end else begin
                        cnt_n = sat_inc(cnt);
                    end
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            HELD: begin
                if (ks == '0) begin
                    cnt_n   = CNT_W'(1);
                    state_n = (DEB_LAST == '0) ? IDLE : REL_DEB;
                end
            end
            REL_DEB: begin
                if (ks == '0) begin
                    if (cnt >= DEB_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = sat_inc(cnt);
                    end
                end else begin
                    state_n = HELD;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef KEY_ONEHOT_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
    logic             rep_phase, rep_phase_n;   // 0: initial delay, 1: periodic
    logic             rep_fire;

    // Auto-repeat timer: runs while staying in HELD, freezes in REL_DEB,
    // restarts from the delay phase on every entry into HELD.
    always_comb begin
        rep_cnt_n   = rep_cnt;
        rep_phase_n = rep_phase;
        rep_fire    = 1'b0;
        if (state_n == IDLE) begin
            rep_cnt_n   = '0;
            rep_phase_n = 1'b0;
        end else if (state == HELD && state_n == HELD) begin
            if (rep_cnt >= (rep_phase ? PER_LAST : DLY_LAST)) begin
                rep_fire    = 1'b1;
                rep_cnt_n   = '0;
                rep_phase_n = 1'b1;
            end else begin
                rep_cnt_n = sat_inc(rep_cnt);
            end
        end else if (state != HELD && state_n == HELD) begin
            rep_cnt_n   = '0;
            rep_phase_n = 1'b0;
        end
    end

    // Auto-repeat timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_n;
            rep_phase <= rep_phase_n;
        end
    end

    assign strobe = accept | rep_fire;
`else
    assign strobe = accept;
`endif

    // State, counter and registered outputs; one_of_8 changes only on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            one_of_8  <= ONEHOT_RESET;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            if (accept) begin
                one_of_8 <= cand_n;
            end
            key_valid <= strobe;
            key_held  <= (state_n == HELD) || (state_n == REL_DEB);
            multi_key <= is_multi(ks);
        end
    end

endmodule

// File: tb/tb_key_onehot_capture.sv
// Scoreboard bench for key_onehot_capture: expected strobes (code and edge
// number) are queued as stimulus is applied and consumed when key_valid fires.
module tb_key_onehot_capture;

    localparam int DEB = 4;
    localparam int RD  = 8;
    localparam int RP  = 4;

    typedef struct {
        logic [7:0] code;
        int         at_edge;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] keys_raw;
    logic [7:0] one_of_8;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_no = 0;
    exp_t sb[$];

    key_onehot_capture #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keys_raw  (keys_raw),
        .one_of_8  (one_of_8),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    // Downstream decoder model: index of the set bit.
    function automatic logic [3:0] to_bcd(input logic [7:0] v);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Queue a strobe for a key held stable from the next edge on.
    task automatic expect_press(input logic [7:0] code);
        exp_t e;
        e.code    = code;
        e.at_edge = edge_no + DEB + 2;
        sb.push_back(e);
    endtask

    task automatic expect_at(input logic [7:0] code, input int at);
        exp_t e;
        e.code    = code;
        e.at_edge = at;
        sb.push_back(e);
    endtask

    // Strobe monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        edge_no = edge_no + 1;
        #1;
        if (key_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", 32'(key_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("strobe_code", 32'(one_of_8), 32'(e.code));
                chk("strobe_edge", 32'(edge_no), 32'(e.at_edge));
            end
        end
    end

    initial begin
        int e0;
        rst      = 1'b1;
        keys_raw = 8'h00;
        step(3);
        chk("rst_onehot", 32'(one_of_8), 32'h01);
        chk("rst_valid", 32'(key_valid), 32'(0));
        chk("rst_held", 32'(key_held), 32'(0));
        chk("rst_multi", 32'(multi_key), 32'(0));
        rst = 1'b0;
        step(2);

        // Two keys at once: flagged, never accepted.
        keys_raw = 8'h03;
        step(2);
        chk("multi_early", 32'(multi_key), 32'(0));
        step(1);
        chk("multi_set", 32'(multi_key), 32'(1));
        step(6);
        chk("multi_onehot", 32'(one_of_8), 32'h01);
        chk("multi_noheld", 32'(key_held), 32'(0));
        keys_raw = 8'h00;
        step(4);
        chk("multi_clear", 32'(multi_key), 32'(0));

        // Clean press of key 5, then release.
        keys_raw = 8'h20;
        expect_press(8'h20);
        step(8);
        chk("clean_code", 32'(one_of_8), 32'h20);
        chk("clean_bcd", 32'(to_bcd(one_of_8)), 32'h5);
        chk("clean_held", 32'(key_held), 32'(1));
        keys_raw = 8'h00;
        step(5);
        chk("clean_rel_still", 32'(key_held), 32'(1));
        step(1);
        chk("clean_rel_done", 32'(key_held), 32'(0));
        step(2);
        chk("clean_sb", 32'(sb.size()), 32'(0));

        // Press bounce on key 2.
        keys_raw = 8'h04; step(1);
        keys_raw = 8'h00; step(1);
        keys_raw = 8'h04; step(1);
        keys_raw = 8'h00; step(1);
        keys_raw = 8'h04;
        expect_press(8'h04);
        step(8);
        chk("bounce_bcd", 32'(to_bcd(one_of_8)), 32'h2);
        keys_raw = 8'h00;
        step(8);
        chk("bounce_sb", 32'(sb.size()), 32'(0));

        // Extra key while key 3 is held.
        keys_raw = 8'h08;
        expect_press(8'h08);
        step(8);
        keys_raw = 8'h48;
        step(4);
        chk("held_multi", 32'(multi_key), 32'(1));
        chk("held_multi_code", 32'(one_of_8), 32'h08);
        chk("held_multi_held", 32'(key_held), 32'(1));
        keys_raw = 8'h08;
        step(4);
        chk("held_multi_clr", 32'(multi_key), 32'(0));
        keys_raw = 8'h00;
        step(8);
        chk("held_multi_rel", 32'(key_held), 32'(0));
        chk("held_multi_sb", 32'(sb.size()), 32'(0));

        // Release bounce on key 7.
        keys_raw = 8'h80;
        expect_press(8'h80);
        step(8);
        keys_raw = 8'h00; step(2);
        keys_raw = 8'h80; step(1);
        keys_raw = 8'h00;
        step(3);
        chk("relb_held_mid", 32'(key_held), 32'(1));
        step(2);
        chk("relb_held_late", 32'(key_held), 32'(1));
        step(1);
        chk("relb_idle", 32'(key_held), 32'(0));
        keys_raw = 8'h01;
        expect_press(8'h01);
        step(8);
        chk("relb_next", 32'(one_of_8), 32'h01);
        keys_raw = 8'h00;
        step(8);
        chk("relb_sb", 32'(sb.size()), 32'(0));

        // Reset during PRESS_DEB, then during HELD, with key 1 kept down.
        keys_raw = 8'h02;
        step(3);
        rst = 1'b1;
        step(1);
        chk("rstp_onehot", 32'(one_of_8), 32'h01);
        chk("rstp_held", 32'(key_held), 32'(0));
        rst = 1'b0;
        expect_press(8'h02);
        step(8);
        chk("rstp_code", 32'(one_of_8), 32'h02);
        rst = 1'b1;
        step(1);
        chk("rsth_onehot", 32'(one_of_8), 32'h01);
        chk("rsth_held", 32'(key_held), 32'(0));
        chk("rsth_valid", 32'(key_valid), 32'(0));
        chk("rsth_multi", 32'(multi_key), 32'(0));
        rst = 1'b0;
        expect_press(8'h02);
        step(8);
        chk("rsth_code", 32'(one_of_8), 32'h02);
        keys_raw = 8'h00;
        step(8);
        chk("rst_sb", 32'(sb.size()), 32'(0));

        // Long hold on key 4: auto-repeat when built in, single strobe otherwise.
        e0 = edge_no;
        keys_raw = 8'h10;
        expect_press(8'h10);
`ifdef KEY_ONEHOT_AUTOREPEAT_EN
        for (int t = e0 + DEB + 2 + RD; t < e0 + 24 + 3; t += RP) begin
            expect_at(8'h10, t);
        end
`endif
        step(24);
        keys_raw = 8'h00;
        step(8);
        chk("rep_code", 32'(one_of_8), 32'h10);
        chk("rep_sb", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
